// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} registered with a one-cycle ready pulse.
module div_radix2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               signed_div_i,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [5:0] LastIter = 6'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [2*WIDTH:0]     work_q, work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;
    logic                 div0_q, div0_d;
    logic                 ready_q, ready_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 abort;
    logic [WIDTH-1:0]     abs1, abs2;
    logic [2*WIDTH:0]     shifted;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     quo, rem;

    always_comb begin
        abort   = flush | annul_i;
        abs1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted = work_q << 1;
        trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_q};
        quo     = work_q[WIDTH-1:0];
        rem     = work_q[2*WIDTH-1:WIDTH];

        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        div0_d    = div0_q;
        ready_d   = 1'b0;
        result_d  = result_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort) begin
                    divisor_d = abs2;
                    neg_q_d   = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r_d   = signed_div_i & opdata1_i[WIDTH-1];
                    cnt_d     = '0;
                    if (opdata2_i == '0) begin
                        // Raw dividend kept so it can be returned unmodified as the remainder.
                        div0_d  = 1'b1;
                        work_d  = {{(WIDTH+1){1'b0}}, opdata1_i};
                        state_d = StDone;
                    end else begin
                        div0_d  = 1'b0;
                        work_d  = {{(WIDTH+1){1'b0}}, abs1};
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (!trial[WIDTH]) begin
                    work_d    = {trial, shifted[WIDTH-1:0]};
                    work_d[0] = 1'b1;
                end else begin
                    work_d = shifted;
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LastIter) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ready_d = 1'b1;
                state_d = StIdle;
                if (div0_q) begin
                    result_d = {quo, {WIDTH{1'b1}}};
                end else begin
                    result_d = {(neg_r_q ? -rem : rem), (neg_q_q ? -quo : quo)};
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything, including the DONE write-back.
        if (abort) begin
            state_d  = StIdle;
            ready_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            div0_q    <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            div0_q    <= div0_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// Scoreboard bench for div_radix2: expectations queued at issue, checked on ready_o.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        signed_div_i;
    logic        ready_o;
    logic [63:0] result_o;

    logic [63:0] sb[$];
    logic [63:0] last_exp = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    div_radix2 #(.WIDTH(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .annul_i      (annul_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .ready_o      (ready_o),
        .result_o     (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [31:0] ua, ub, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        ua = (s && a[31]) ? -a : a;
        ub = (s && b[31]) ? -b : b;
        q  = ua / ub;
        r  = ua % ub;
        if (s && (a[31] ^ b[31])) q = -q;
        if (s && a[31]) r = -r;
        return {r, q};
    endfunction

    // Result monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && ready_o) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("result", result_o, e);
                last_exp = e;
            end
        end
    end

    // Called at a negedge; returns at a negedge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int exp_lat);
        int lat;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (ready_o) break;
            @(posedge clk);
            lat++;
        end
        start_i = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check("ready_low_after", {63'd0, ready_o}, 64'd0);
    endtask

    task automatic abort_div(input logic use_annul);
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        if (use_annul) annul_i = 1'b1;
        else flush = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        flush   = 1'b0;
        annul_i = 1'b0;
        check(use_annul ? "annul_hold" : "flush_hold", result_o, last_exp);
        run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);
    endtask

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        annul_i      = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
        run_div(-32'sd7, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div(32'd7, -32'sd2, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, 33);
        run_div(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
        run_div(32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0}, 33);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            s = i[0] ^ i[1];
            run_div(a, b, s, model(a, b, s), 33);
        end

        abort_div(1'b0);
        abort_div(1'b1);

        // Asynchronous reset in the middle of BUSY.
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ready", {63'd0, ready_o}, 64'd0);
        check("async_rst_result", result_o, 64'd0);
        start_i  = 1'b0;
        last_exp = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative radix-2 restoring divider that serves the execute-stage ALU for DIV/DIVU. The ALU holds `start_i` high and stalls until `ready_o` pulses. It then writes `result_o` into HI/LO: remainder goes to HI, quotient to LO. The block runs one quotient bit per cycle, handles signed and unsigned operands, and aborts cleanly on pipeline flush.

## Interface
Parameters:
- `WIDTH`, 32: operand width; `result_o` is 2*WIDTH.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `annul_i`  in  1  cancel request; same effect as `flush`.
- `opdata1_i`  in  WIDTH  dividend; sampled only on the accepting edge.
- `opdata2_i`  in  WIDTH  divisor; sampled only on the accepting edge.
- `start_i`  in  1  request; held high by the ALU until `ready_o`.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with the operands.
- `ready_o`  out  1  result valid; one-cycle pulse.
- `result_o`  out  2*WIDTH  {remainder, quotient}; [63:32] = remainder, [31:0] = quotient.

## Operation
- Registered FSM with states IDLE, BUSY, DONE. Internal 6-bit iteration counter.
- IDLE, with `start_i & ~flush & ~annul_i` at an edge:
  - Latch the operands and `signed_div_i`.
  - If signed, latch |dividend| and |divisor|; record `neg_q` = sign1 ^ sign2 and `neg_r` = sign1.
  - Divisor == 0 → DONE.
  - Otherwise → BUSY with counter = 0 and working register {33'b0, |dividend|}.
- BUSY, each cycle:
  - Shift the working register left by 1.
  - Trial-subtract |divisor| from the upper 33 bits.
  - If non-negative, keep the difference and set quotient bit 1; else restore and set bit 0.
  - Increment the counter; after the 32nd iteration → DONE.
- DONE:
  - `ready_o` = 1 for exactly one cycle.
  - `result_o` carries the final values: quotient negated if `neg_q`, remainder negated if `neg_r`.
  - → IDLE unconditionally.
- `result_o` is registered on entry to DONE and holds until the next DONE. It does not change in IDLE or BUSY.
- Divide-by-zero: quotient = 32'hFFFF_FFFF, remainder = dividend as given (unsigned, no sign fix). Never raises an exception.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF: quotient = 32'h8000_0000, remainder = 0. This wraps naturally; no special case.
- Remainder sign always follows the dividend; |remainder| < |divisor|.
- `flush` or `annul_i` high at an edge in any state:
  - → IDLE; `ready_o` stays 0.
  - `result_o` is unchanged; no start is accepted on that edge.
  - Flush has priority over start and over DONE.
- `start_i` is ignored outside IDLE. Operand changes during BUSY have no effect.
- If `start_i` is still high in IDLE after DONE (ALU stalled by another cause), a new division begins. This is legal; the same result is produced again.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, `ready_o` 0, `result_o` 0.
- Latency, normal case: start accepted at edge E0 → BUSY during E0+1..E0+32 → DONE. `ready_o` is high in the cycle after edge E0+33, i.e. 33 cycles after acceptance.
- Latency, divide-by-zero: `ready_o` is high in the cycle after E0+1.
- `ready_o` is a flop output, not combinational from inputs. The ALU deasserts `start_i` and writes HI/LO in that same cycle.
- Throughput: one division per 34 cycles. Back-to-back starts are accepted on the edge that leaves DONE for IDLE plus one, i.e. the first IDLE cycle.
- Reset asserted mid-operation: immediate IDLE, `ready_o` 0, `result_o` 0.

## Test plan
- Unsigned 100 / 7 (`signed_div_i`=0), `start_i` held until `ready_o`: `ready_o` pulses exactly once, 33 cycles after acceptance; `result_o` = {32'd2, 32'd14}; `ready_o` low the following cycle.
- Signed -7 / 2: quotient 32'hFFFF_FFFD, remainder 32'hFFFF_FFFF. Signed 7 / -2: quotient 32'hFFFF_FFFD, remainder 32'd1. Unsigned 32'hFFFF_FFF9 / 2: quotient 32'h7FFF_FFFC, remainder 1.
- Divide-by-zero, 32'h1234_5678 / 0 (either signedness): `ready_o` in the cycle after acceptance; `result_o` = {32'h1234_5678, 32'hFFFF_FFFF}.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF → {0, 32'h8000_0000}. Unsigned same operands → {32'h8000_0000, 0}.
- Abort: `flush` pulsed 10 cycles into BUSY → no `ready_o` ever for that operation; `result_o` keeps its old value. A new start of 9 / 3 one cycle later returns {0, 3} after 33 cycles. Repeat the check using `annul_i`.
- Reset mid-operation: `rst` driven low asynchronously at cycle 20 of BUSY → outputs go to 0 immediately without a clock edge. After release, 50 / 5 completes with {0, 10}.
